// File: rtl/input_capture_ctrl.sv
// input_capture_ctrl
// Front end for the 4-bit code converter. It synchronizes the data switches
// and the OK/CLEAR push-buttons to clk and debounces both buttons. A debounced
// OK latches the switch word and raises ready. A debounced CLEAR drops ready
// and zeroes the data. Accepted captures are counted modulo 16.
module input_capture_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_ok,
    input  logic       btn_clr,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       ready,
    output logic       busy,
    output logic [3:0] cap_cnt
);

    // Terminal value of the debounce counter: a button must be seen high on
    // DEB_CYCLES consecutive edges, and the first of those loads cnt=1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEB_OK   = 2'd1,
        DEB_CLR  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Two-flop synchronizer stages
    logic [3:0] sw_m;
    logic [3:0] sw_s;
    logic       ok_m;
    logic       ok_s;
    logic       clr_m;
    logic       clr_s;

    // FSM and datapath state
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       data;
    logic             do_capture;
    logic             do_clear;

    // Bring the raw pins into the clk domain; only the *_s copies are used.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_m  <= '0;
            sw_s  <= '0;
            ok_m  <= 1'b0;
            ok_s  <= 1'b0;
            clr_m <= 1'b0;
            clr_s <= 1'b0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            ok_m  <= btn_ok;
            ok_s  <= ok_m;
            clr_m <= btn_clr;
            clr_s <= clr_m;
        end
    end

    // Next-state, debounce counter and capture/clear strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_capture = 1'b0;
        do_clear   = 1'b0;
        case (state)
            IDLE: begin
                // CLEAR wins when both buttons are high
                if (clr_s) begin
                    state_next = DEB_CLR;
                    cnt_next   = CNT_ONE;
                end else if (ok_s) begin
                    state_next = DEB_OK;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            DEB_OK: begin
                if (!ok_s) begin
                    // glitch: abandon without touching ready/data
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (clr_s) begin
                    state_next = DEB_CLR;
                    cnt_next   = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    do_capture = 1'b1;
                    state_next = WAIT_REL;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            DEB_CLR: begin
                if (!clr_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    do_clear   = 1'b1;
                    state_next = WAIT_REL;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            WAIT_REL: begin
                // count DEB_CYCLES consecutive all-low cycles: cnt 0..CNT_LAST
                if (ok_s || clr_s) begin
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register plus registered outputs driven by the strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            data    <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            cap_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // busy is registered from the next state so it tracks state exactly
            busy  <= (state_next != IDLE);
            if (do_capture) begin
                data    <= sw_s;
                ready   <= 1'b1;
                cap_cnt <= cap_cnt + 4'd1;
            end else if (do_clear) begin
                data    <= '0;
                ready   <= 1'b0;
            end
        end
    end

    assign A = data[3];
    assign B = data[2];
    assign C = data[1];
    assign D = data[0];

endmodule
